// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_if
// Description : Bus bundle for the VRAM arbiter. Carries the CPU write
//               handshake, the display fetch control, the VRAM read/write
//               port and the fetched-character stream.
//               slave  modport : the arbiter side
//               master modport : the environment side (CPU, line-prep, VRAM,
//                                glyph pipeline)
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int ROW_W  = 5,
    parameter int COL_W  = 7
);
    // CPU write path
    logic              cpu_wr_valid;
    logic              cpu_wr_ready;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    // Display fetch control
    logic              disp_start;
    logic [ROW_W-1:0]  disp_row;
    logic              disp_busy;
    logic              disp_overrun;
    // VRAM port
    logic              vram_re;
    logic [ADDR_W-1:0] vram_raddr;
    logic [DATA_W-1:0] vram_rdata;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_waddr;
    logic [DATA_W-1:0] vram_wdata;
    // Fetched character stream
    logic              char_valid;
    logic [COL_W-1:0]  char_col;
    logic [DATA_W-1:0] char_data;

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        input  disp_start, disp_row,
        input  vram_rdata,
        output cpu_wr_ready,
        output disp_busy, disp_overrun,
        output vram_re, vram_raddr, vram_we, vram_waddr, vram_wdata,
        output char_valid, char_col, char_data
    );

    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        output disp_start, disp_row,
        output vram_rdata,
        input  cpu_wr_ready,
        input  disp_busy, disp_overrun,
        input  vram_re, vram_raddr, vram_we, vram_waddr, vram_wdata,
        input  char_valid, char_col, char_data
    );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares the VRAM between buffered CPU writes and the display
//               character fetch. CPU writes enter a small in-order FIFO. While
//               idle the FIFO drains one entry per clock; during a row fetch
//               each 8-clock tile slot issues one character read (slot 0) and
//               offers a single write opportunity (slot 4). Read data returns
//               one clock later as a column-tagged character stream.
// Ports       : clk   - system clock (posedge)
//               rst_n - asynchronous active-low reset
//               bus   - vram_arbiter_if.slave: CPU write handshake,
//                       disp_start/disp_row/disp_busy/disp_overrun,
//                       VRAM read/write port, char_valid/char_col/char_data
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int HTILES     = 80,
    parameter int ROW_W      = 5,
    parameter int COL_W      = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    vram_arbiter_if.slave bus
);

    localparam int                  c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int                  c_cnt_w    = c_ptr_w + 1;
    localparam logic [COL_W-1:0]    c_last_col = COL_W'(HTILES - 1);
    localparam logic [ADDR_W-1:0]   c_htiles   = ADDR_W'(HTILES);
    localparam logic [c_cnt_w-1:0]  c_full_cnt = c_cnt_w'(FIFO_DEPTH);
    localparam logic [2:0]          c_rd_slot  = 3'd0;
    localparam logic [2:0]          c_wr_slot  = 3'd4;
    localparam logic [2:0]          c_end_slot = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              r_state, w_state_nxt;
    logic [2:0]          r_slot, w_slot_nxt;
    logic [COL_W-1:0]    r_col, w_col_nxt;
    logic [ADDR_W-1:0]   r_base, w_base_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic                r_rst_done;
    logic                r_char_valid;
    logic [COL_W-1:0]    r_char_col;

    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_full, w_empty, w_ready, w_push, w_pop, w_re;
    logic [ADDR_W-1:0]   w_row_base;

    // ------------------------------------------------------------------
    // FIFO status and handshake
    // ------------------------------------------------------------------
    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);
    // Held low until the first clock after reset release so that every
    // output reads 0 while reset is applied.
    assign w_ready = r_rst_done && !w_full;
    assign w_push  = bus.cpu_wr_valid && w_ready;

    // Row base is computed in ADDR_W bits so it wraps modulo the VRAM size.
    assign w_row_base = ADDR_W'(bus.disp_row) * c_htiles;

    // ------------------------------------------------------------------
    // FSM next-state and slot sequencing
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_slot_nxt    = r_slot;
        w_col_nxt     = r_col;
        w_base_nxt    = r_base;
        w_overrun_nxt = r_overrun;
        w_pop         = 1'b0;
        w_re          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Full-rate drain; still happens in a disp_start cycle.
                w_pop = !w_empty;
                if (bus.disp_start) begin
                    w_state_nxt = ST_FETCH;
                    w_slot_nxt  = '0;
                    w_col_nxt   = '0;
                    w_base_nxt  = w_row_base;
                end
            end
            ST_FETCH: begin
                w_slot_nxt = r_slot + 3'd1;
                if (r_slot == c_rd_slot) begin
                    w_re = 1'b1;
                end
                if (r_slot == c_wr_slot) begin
                    w_pop = !w_empty;
                end
                if (r_slot == c_end_slot) begin
                    if (r_col == c_last_col) begin
                        w_state_nxt = ST_IDLE;
                        w_col_nxt   = '0;
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                    end
                end
                // A restart request mid-row is dropped but remembered.
                if (bus.disp_start) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_slot       <= '0;
            r_col        <= '0;
            r_base       <= '0;
            r_overrun    <= 1'b0;
            r_rst_done   <= 1'b0;
            r_char_valid <= 1'b0;
            r_char_col   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_col        <= w_col_nxt;
            r_base       <= w_base_nxt;
            r_overrun    <= w_overrun_nxt;
            r_rst_done   <= 1'b1;
            // Read data arrives one clock after vram_re; tag it with the
            // column that issued the read.
            r_char_valid <= w_re;
            if (w_re) begin
                r_char_col <= r_col;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // FIFO storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.cpu_wr_addr;
            r_fifo_data[r_wr_ptr] <= bus.cpu_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (buses forced to 0 when their strobe is low)
    // ------------------------------------------------------------------
    assign bus.cpu_wr_ready = w_ready;
    assign bus.disp_busy    = (r_state == ST_FETCH);
    assign bus.disp_overrun = r_overrun;
    assign bus.vram_re      = w_re;
    assign bus.vram_raddr   = w_re ? (r_base + ADDR_W'(r_col)) : '0;
    assign bus.vram_we      = w_pop;
    assign bus.vram_waddr   = w_pop ? r_fifo_addr[r_rd_ptr] : '0;
    assign bus.vram_wdata   = w_pop ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.char_valid   = r_char_valid;
    assign bus.char_col     = r_char_valid ? r_char_col : '0;
    assign bus.char_data    = r_char_valid ? bus.vram_rdata : '0;

endmodule
`default_nettype wire
